// File: rtl/collision_ctrl.sv
// collision_ctrl -- round state machine and collision/score judge for the
// flappy-bird game core.
//
// Ports:
//   Clk, reset          rising-edge clock, synchronous active-high reset
//   Start               level, leaves INIT and begins a round (clears Score)
//   Ack                 level, leaves DEAD back to INIT
//   Frame_Tick          one-cycle pulse per frame; positions only judged then
//   Bird_X, Bird_Y      signed 10-bit bird left/top edge
//   Pipe_X, Gap_Y       unsigned 10-bit pipe column left edge / gap top edge
//   q_Init/q_Play/q_Dead one-hot state flags (registered)
//   Phys_Hold           high in INIT or DEAD, freezes flight physics
//   Collision           one-cycle pulse in the cycle after PLAY->DEAD
//   Score               pipes passed this round, saturating at 255
module collision_ctrl #(
  parameter int BIRD_SIZE  = 32'sd16,
  parameter int PIPE_WIDTH = 32'sd40,
  parameter int GAP_HEIGHT = 32'sd120,
  parameter int GROUND_Y   = 32'sd464
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              Start,
  input  logic              Ack,
  input  logic              Frame_Tick,
  input  logic signed [9:0] Bird_X,
  input  logic signed [9:0] Bird_Y,
  input  logic        [9:0] Pipe_X,
  input  logic        [9:0] Gap_Y,
  output logic              q_Init,
  output logic              q_Play,
  output logic              q_Dead,
  output logic              Phys_Hold,
  output logic              Collision,
  output logic        [7:0] Score
);

  // One-hot encoding so the q_* flags are plain register bits.
  typedef enum logic [2:0] {
    ST_INIT = 3'b001,
    ST_PLAY = 3'b010,
    ST_DEAD = 3'b100
  } state_t;

  // 12 bits signed holds every sum below (max 1023+120) without overflow.
  localparam logic signed [11:0] BIRD_SIZE_C  = 12'(BIRD_SIZE);
  localparam logic signed [11:0] PIPE_WIDTH_C = 12'(PIPE_WIDTH);
  localparam logic signed [11:0] GAP_HEIGHT_C = 12'(GAP_HEIGHT);
  localparam logic signed [11:0] GROUND_Y_C   = 12'(GROUND_Y);

  state_t              state_r;
  logic                phys_hold_r;
  logic                collision_r;
  logic          [7:0] score_r;
  logic                scored_r;

  logic signed  [11:0] bird_x_s;
  logic signed  [11:0] bird_y_s;
  logic signed  [11:0] pipe_x_s;
  logic signed  [11:0] gap_y_s;
  logic signed  [11:0] pipe_right_s;
  logic                overlap_x_s;
  logic                outside_gap_s;
  logic                hit_s;
  logic                pipe_behind_s;
  logic                pass_s;

  // Widen inputs: signed positions sign-extend, unsigned ones zero-extend.
  always_comb begin
    bird_x_s     = {{2{Bird_X[9]}}, Bird_X};
    bird_y_s     = {{2{Bird_Y[9]}}, Bird_Y};
    pipe_x_s     = {2'b00, Pipe_X};
    gap_y_s      = {2'b00, Gap_Y};
    pipe_right_s = pipe_x_s + PIPE_WIDTH_C;
  end

  // Hit/pass judgement; strict comparisons so touching edges are not hits.
  always_comb begin
    overlap_x_s   = ((bird_x_s + BIRD_SIZE_C) > pipe_x_s) && (bird_x_s < pipe_right_s);
    outside_gap_s = (bird_y_s < gap_y_s) ||
                    ((bird_y_s + BIRD_SIZE_C) > (gap_y_s + GAP_HEIGHT_C));
    hit_s         = (bird_y_s < 12'sd0) || (bird_y_s > GROUND_Y_C) ||
                    (overlap_x_s && outside_gap_s);
    pipe_behind_s = pipe_right_s < bird_x_s;
    pass_s        = pipe_behind_s && !scored_r;
  end

  // Round FSM with its registered outputs, score counter and scored flag.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_r     <= ST_INIT;
      phys_hold_r <= 1'b1;
      collision_r <= 1'b0;
      score_r     <= 8'd0;
      scored_r    <= 1'b0;
    end else begin
      collision_r <= 1'b0;
      case (state_r)
        ST_INIT: begin
          if (Start) begin
            state_r     <= ST_PLAY;
            phys_hold_r <= 1'b0;
            score_r     <= 8'd0;
          end else begin
            phys_hold_r <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (Frame_Tick) begin
            // A pipe at or ahead of the bird re-arms scoring for that pipe.
            if (!pipe_behind_s) begin
              scored_r <= 1'b0;
            end else if (pass_s && !hit_s) begin
              scored_r <= 1'b1;
            end else begin
              scored_r <= scored_r;
            end
            if (hit_s) begin
              state_r     <= ST_DEAD;
              phys_hold_r <= 1'b1;
              collision_r <= 1'b1;
            end else if (pass_s && (score_r != 8'd255)) begin
              score_r <= score_r + 8'd1;
            end else begin
              score_r <= score_r;
            end
          end else begin
            phys_hold_r <= 1'b0;
          end
        end
        ST_DEAD: begin
          phys_hold_r <= 1'b1;
          if (Ack) begin
            state_r <= ST_INIT;
          end else begin
            state_r <= ST_DEAD;
          end
        end
        default: begin
          state_r     <= ST_INIT;
          phys_hold_r <= 1'b1;
          score_r     <= 8'd0;
          scored_r    <= 1'b0;
        end
      endcase
    end
  end

  assign q_Init    = state_r[0];
  assign q_Play    = state_r[1];
  assign q_Dead    = state_r[2];
  assign Phys_Hold = phys_hold_r;
  assign Collision = collision_r;
  assign Score     = score_r;

endmodule
